// File: rtl/lzy_hc_seq_kit.sv
// lzy_hc_seq_kit: three HC-series sequential functions on one clock and reset.
//   - J-K flip-flop with asynchronous active-low set/clear (74HC112 style)
//   - presettable binary counter with terminal count (74HC161 style)
//   - four-mode universal shift register (74HC194 style)
// The sections share only Clk and Reset.
module lzy_hc_seq_kit #(
    parameter int CNT_WIDTH = 4,
    parameter int SR_WIDTH  = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Sd,
    input  logic                 Rd,
    input  logic                 J,
    input  logic                 K,
    output logic                 Q_jk,
    output logic                 Qn_jk,
    input  logic                 CEP,
    input  logic                 CET,
    input  logic                 PE,
    input  logic [CNT_WIDTH-1:0] D_cnt,
    output logic [CNT_WIDTH-1:0] Q_cnt,
    output logic                 TC,
    input  logic [1:0]           S,
    input  logic                 Dsr,
    input  logic                 Dsl,
    input  logic [0:SR_WIDTH-1]  D_sr,
    output logic [0:SR_WIDTH-1]  Q_sr
);

    typedef enum logic [1:0] {
        SR_HOLD  = 2'b00,
        SR_RIGHT = 2'b01,
        SR_LEFT  = 2'b10,
        SR_LOAD  = 2'b11
    } sr_mode_e;

    logic jk_state;

    // J-K storage: Reset wins, then preset, then clear, then the clocked J/K table.
    // With both Sd and Rd low the stored bit is held at 1 so release shows Q=1.
    always_ff @(posedge Clk or posedge Reset or negedge Sd or negedge Rd) begin
        if (Reset) begin
            jk_state <= 1'b0;
        end else if (!Sd) begin
            jk_state <= 1'b1;
        end else if (!Rd) begin
            jk_state <= 1'b0;
        end else begin
            case ({J, K})
                2'b01:   jk_state <= 1'b0;
                2'b10:   jk_state <= 1'b1;
                2'b11:   jk_state <= ~jk_state;
                default: jk_state <= jk_state;
            endcase
        end
    end

    // J-K outputs follow the async controls directly so they respond without
    // waiting for the storage element; Sd=Rd=0 drives both outputs high.
    always_comb begin
        Q_jk  = jk_state;
        Qn_jk = ~jk_state;
        if (Reset) begin
            Q_jk  = 1'b0;
            Qn_jk = 1'b1;
        end else if (!Sd && !Rd) begin
            Q_jk  = 1'b1;
            Qn_jk = 1'b1;
        end else if (!Sd) begin
            Q_jk  = 1'b1;
            Qn_jk = 1'b0;
        end else if (!Rd) begin
            Q_jk  = 1'b0;
            Qn_jk = 1'b1;
        end
    end

    // Counter: synchronous load overrides counting; counting needs both enables.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Q_cnt <= '0;
        end else if (!PE) begin
            Q_cnt <= D_cnt;
        end else if (CEP && CET) begin
            Q_cnt <= Q_cnt + CNT_WIDTH'(1);
        end
    end

    // Terminal count only looks at CET and the current value.
    assign TC = CET & (&Q_cnt);

    // Shift register: bit 0 is leftmost, so shifting right feeds Dsr into bit 0.
    // Any select value that matches no mode (including unknowns) holds.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Q_sr <= '0;
        end else begin
            case (S)
                SR_RIGHT: Q_sr <= {Dsr, Q_sr[0:SR_WIDTH-2]};
                SR_LEFT:  Q_sr <= {Q_sr[1:SR_WIDTH-1], Dsl};
                SR_LOAD:  Q_sr <= D_sr;
                default:  Q_sr <= Q_sr;
            endcase
        end
    end

endmodule

// File: tb/tb_lzy_hc_seq_kit.sv
// Testbench for lzy_hc_seq_kit: directed sequences plus a random soak, checked
// through a scoreboard queue fed by a behavioural model of the three sections.
module tb_lzy_hc_seq_kit;

    localparam int CW = 4;
    localparam int SW = 4;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Sd, Rd, J, K;
    logic          Q_jk, Qn_jk;
    logic          CEP, CET, PE;
    logic [CW-1:0] D_cnt;
    logic [CW-1:0] Q_cnt;
    logic          TC;
    logic [1:0]    S;
    logic          Dsr, Dsl;
    logic [0:SW-1] D_sr;
    logic [0:SW-1] Q_sr;

    lzy_hc_seq_kit #(.CNT_WIDTH(CW), .SR_WIDTH(SW)) dut (
        .Clk(Clk), .Reset(Reset), .Sd(Sd), .Rd(Rd), .J(J), .K(K),
        .Q_jk(Q_jk), .Qn_jk(Qn_jk), .CEP(CEP), .CET(CET), .PE(PE),
        .D_cnt(D_cnt), .Q_cnt(Q_cnt), .TC(TC), .S(S), .Dsr(Dsr), .Dsl(Dsl),
        .D_sr(D_sr), .Q_sr(Q_sr)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string         name;
        logic          q;
        logic          qn;
        logic [CW-1:0] cnt;
        logic          tc;
        logic [0:SW-1] sr;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    event sample_ev;

    // Reference state: plain bit, integer and array
    bit m_jk;
    int m_cnt;
    bit m_sr[SW];

    function automatic void modelAsync();
        if (Reset) begin
            m_jk  = 1'b0;
            m_cnt = 0;
            foreach (m_sr[i]) m_sr[i] = 1'b0;
        end else if (!Sd) begin
            m_jk = 1'b1;
        end else if (!Rd) begin
            m_jk = 1'b0;
        end
    endfunction

    function automatic void modelEdge();
        bit nxt[SW];
        if (Reset) return;
        if (!Sd)           m_jk = 1'b1;
        else if (!Rd)      m_jk = 1'b0;
        else if (J && K)   m_jk = !m_jk;
        else if (J)        m_jk = 1'b1;
        else if (K)        m_jk = 1'b0;
        if (!PE)             m_cnt = int'(D_cnt);
        else if (CEP && CET) m_cnt = (m_cnt + 1) % (1 << CW);
        nxt = m_sr;
        if (S == 2'd1) begin
            nxt[0] = Dsr;
            for (int i = 1; i < SW; i++) nxt[i] = m_sr[i-1];
        end else if (S == 2'd2) begin
            for (int i = 0; i < SW - 1; i++) nxt[i] = m_sr[i+1];
            nxt[SW-1] = Dsl;
        end else if (S == 2'd3) begin
            for (int i = 0; i < SW; i++) nxt[i] = D_sr[i];
        end
        m_sr = nxt;
    endfunction

    function automatic exp_t expected(input string name);
        exp_t e;
        e.name = name;
        if (Reset)      e.q = 1'b0;
        else if (!Sd)   e.q = 1'b1;
        else if (!Rd)   e.q = 1'b0;
        else            e.q = m_jk;
        if (Reset)              e.qn = 1'b1;
        else if (!Sd && !Rd)    e.qn = 1'b1;
        else                    e.qn = !e.q;
        e.cnt = CW'(m_cnt);
        e.tc  = CET && (m_cnt == (1 << CW) - 1);
        for (int i = 0; i < SW; i++) e.sr[i] = m_sr[i];
        return e;
    endfunction

    // Update the model, queue the expected outputs, optionally wait for an
    // edge, then let the monitor sample.
    task automatic applyStimulus(input string name, input bit clocked);
        modelAsync();
        if (clocked) modelEdge();
        sb.push_back(expected(name));
        if (clocked) @(posedge Clk);
        ->sample_ev;
        #2;
    endtask

    task automatic cmpField(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        cmpField({e.name, ".Q_jk"},  8'(Q_jk),  8'(e.q));
        cmpField({e.name, ".Qn_jk"}, 8'(Qn_jk), 8'(e.qn));
        cmpField({e.name, ".Q_cnt"}, 8'(Q_cnt), 8'(e.cnt));
        cmpField({e.name, ".TC"},    8'(TC),    8'(e.tc));
        cmpField({e.name, ".Q_sr"},  8'(Q_sr),  8'(e.sr));
    endtask

    // Monitor: samples shortly after each sample request and pops the scoreboard.
    initial begin
        forever begin
            @(sample_ev);
            #1;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard_underflow got=0 want=1");
            end else begin
                checkOutput(sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout got=%0t want=finish", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        Reset = 1'b1; Sd = 1'b1; Rd = 1'b1; J = 1'b0; K = 1'b0;
        CEP = 1'b0; CET = 1'b0; PE = 1'b1; D_cnt = '0;
        S = 2'b00; Dsr = 1'b0; Dsl = 1'b0; D_sr = '0;
        #1;
        applyStimulus("reset_async", 0);
        J = 1'b1; CEP = 1'b1; CET = 1'b1; S = 2'b11; D_sr = 4'b1111;
        applyStimulus("reset_hold", 1);
        J = 1'b0; CEP = 1'b0; CET = 1'b0; S = 2'b00;
        Reset = 1'b0;
        applyStimulus("reset_release", 0);

        // J-K asynchronous controls
        Rd = 1'b0; Sd = 1'b1; applyStimulus("jk_rd_low", 0);
        Sd = 1'b0; Rd = 1'b1; applyStimulus("jk_sd_low", 0);
        Sd = 1'b0; Rd = 1'b0; applyStimulus("jk_both_low", 0);
        Sd = 1'b1; Rd = 1'b1; applyStimulus("jk_release", 0);

        // J-K clocked table
        J = 1'b0; K = 1'b1; applyStimulus("jk_clear", 1);
        J = 1'b1; K = 1'b0; applyStimulus("jk_set", 1);
        J = 1'b1; K = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus($sformatf("jk_toggle%0d", i), 1);
        J = 1'b0; K = 1'b1; applyStimulus("jk_01", 1);
        J = 1'b0; K = 1'b0;
        for (int i = 0; i < 2; i++) applyStimulus($sformatf("jk_hold%0d", i), 1);

        // Counter load, count through terminal count and wrap
        PE = 1'b0; D_cnt = 4'hD; applyStimulus("cnt_load", 1);
        PE = 1'b1; CEP = 1'b1; CET = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus($sformatf("cnt_up%0d", i), 1);
        PE = 1'b0; D_cnt = 4'hF; applyStimulus("cnt_load15", 1);
        PE = 1'b1; CET = 1'b0; applyStimulus("tc_cet0", 0);
        applyStimulus("cnt_cet0_hold", 1);
        CEP = 1'b0; CET = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus($sformatf("cnt_cep0_%0d", i), 1);
        CEP = 1'b1;
        applyStimulus("cnt_wrap", 1);
        applyStimulus("cnt_one", 1);
        applyStimulus("cnt_two", 1);
        Reset = 1'b1; applyStimulus("reset_mid", 0);
        Reset = 1'b0; CEP = 1'b0; CET = 1'b0; applyStimulus("reset_mid_release", 0);

        // Shift register modes
        S = 2'b11; D_sr = 4'b1011; applyStimulus("sr_load", 1);
        S = 2'b01; Dsr = 1'b0;     applyStimulus("sr_right", 1);
        S = 2'b10; Dsl = 1'b1;     applyStimulus("sr_left", 1);
        S = 2'b00; D_sr = 4'b0000;
        for (int i = 0; i < 3; i++) applyStimulus($sformatf("sr_hold%0d", i), 1);

        // Random soak
        $display("[TB] random soak");
        Reset = 1'b1; applyStimulus("soak_reset", 0);
        Reset = 1'b0; applyStimulus("soak_release", 0);
        for (int n = 0; n < 100; n++) begin
            Sd    = ($urandom_range(15) != 0);
            Rd    = ($urandom_range(15) != 0);
            J     = 1'($urandom_range(1));
            K     = 1'($urandom_range(1));
            CEP   = ($urandom_range(3) != 0);
            CET   = ($urandom_range(3) != 0);
            PE    = ($urandom_range(7) != 0);
            D_cnt = CW'($urandom_range((1 << CW) - 1));
            S     = 2'($urandom_range(3));
            Dsr   = 1'($urandom_range(1));
            Dsl   = 1'($urandom_range(1));
            D_sr  = SW'($urandom_range((1 << SW) - 1));
            applyStimulus($sformatf("soak%0d", n), 1);
        end

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
